// File: rtl/regfile_dump_reader.sv
// Debug reader that walks the integer register file and streams each register
// out as an (index, value) pair over a valid/ready port.
module regfile_dump_reader #(
    parameter int N        = 64,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [N-1:0]      rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [N-1:0]      out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAP,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_rf_addr;
    logic [ADDR_W-1:0] r_out_index;
    logic [N-1:0]      r_out_data;
    logic              r_out_valid;
    logic              w_fire;
    logic              w_last;

    assign w_fire = r_out_valid & out_ready;
    assign w_last = (r_idx == LAST_IDX);

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_REQ;
            S_REQ:   w_next = S_CAP;
            S_CAP:   w_next = S_SEND;
            S_SEND:  if (w_fire) w_next = w_last ? S_DONE : S_REQ;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // The read address is loaded on entry to REQ, so it is stable for the
    // whole REQ cycle and rf_data is ready in CAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_rf_addr   <= '0;
            r_out_index <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx     <= '0;
                        r_rf_addr <= '0;
                    end
                end
                S_CAP: begin
                    r_out_data  <= rf_data;
                    r_out_index <= r_idx;
                    r_out_valid <= 1'b1;
                end
                S_SEND: begin
                    if (w_fire) begin
                        r_out_valid <= 1'b0;
                        if (!w_last) begin
                            r_idx     <= r_idx + ADDR_W'(1);
                            r_rf_addr <= r_idx + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rf_addr   = r_rf_addr;
    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_data  = r_out_data;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full dumps, backpressure, ignored
// start, mid-dump reset and value extremes against a registered-read RF model.
module tb_regfile_dump_reader;

    localparam int N        = 64;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] rf_addr;
    logic [N-1:0]      rf_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_index;
    logic [N-1:0]      out_data;
    logic              busy;
    logic              done;

    logic [N-1:0] mem [NUM_REGS];
    logic [N-1:0] first_data;
    logic [N-1:0] last_data;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_dump_reader #(.N(N), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Register file read port: data valid one cycle after the address.
    always @(posedge clk) rf_data <= mem[rf_addr];

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One dump from a start pulse. stall_idx gets 5 cycles of out_ready=0,
    // restart_idx gets a second start pulse, abort_idx gets a reset.
    task automatic run_dump(input int stall_idx, input int restart_idx, input int abort_idx,
                            input int exp_pairs, input int exp_done_cyc);
        int   cyc = 0;
        int   n_pairs = 0;
        int   done_cnt = 0;
        int   done_cyc = -1;
        int   first_cyc = -1;
        int   stall_cnt = 0;
        int   abort_cyc = 0;
        bit   prev_stall = 0;
        bit   injected = 0;
        bit   aborted = 0;
        bit   pending = 0;
        logic [ADDR_W-1:0] held_idx = '0;
        logic [N-1:0]      held_data = '0;

        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b1;
        while (cyc < 400 && !(done_cnt > 0 && cyc >= done_cyc + 4)
               && !(aborted && cyc >= abort_cyc + 10)) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) begin
                check("req_addr", N'(rf_addr), '0);
                check("req_busy", N'(busy), 64'd1);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (pending) begin
                check("abort_valid", N'(out_valid), '0);
                check("abort_busy", N'(busy), '0);
                check("abort_index", N'(out_index), '0);
                check("abort_data", out_data, '0);
                reset   = 1'b0;
                pending = 0;
            end else if (aborted) begin
                check("abort_no_resume", N'({busy, out_valid, done}), '0);
            end
            if (prev_stall) begin
                check("stall_valid", N'(out_valid), 64'd1);
                check("stall_index", N'(out_index), N'(held_idx));
                check("stall_data", out_data, held_data);
            end
            prev_stall = 0;
            out_ready  = 1'b1;
            if (out_valid && !aborted) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (abort_idx >= 0 && int'(out_index) == abort_idx) begin
                    reset     = 1'b1;
                    out_ready = 1'b0;
                    aborted   = 1;
                    pending   = 1;
                    abort_cyc = cyc;
                end else if (int'(out_index) == stall_idx && stall_cnt < 5) begin
                    out_ready  = 1'b0;
                    stall_cnt++;
                    prev_stall = 1;
                    held_idx   = out_index;
                    held_data  = out_data;
                end else begin
                    check("pair_index", N'(out_index), N'(n_pairs));
                    check("pair_data", out_data, mem[n_pairs % NUM_REGS]);
                    if (n_pairs == 0) first_data = out_data;
                    last_data = out_data;
                    n_pairs++;
                end
                if (restart_idx >= 0 && int'(out_index) == restart_idx && !injected) begin
                    start    = 1'b1;
                    injected = 1;
                end
            end
        end
        check("pair_count", N'(n_pairs), N'(exp_pairs));
        check("first_valid_cyc", N'(first_cyc), 64'd3);
        check("done_count", N'(done_cnt), aborted ? 64'd0 : 64'd1);
        if (!aborted) check("done_cyc", N'(done_cyc), N'(exp_done_cyc));
        check("end_busy", N'(busy), '0);
        out_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) mem[i] = N'(i) * 64'h1111;

        // 1: reset held two cycles with start high
        reset     = 1'b1;
        start     = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rf_addr", N'(rf_addr), '0);
        check("rst_valid", N'(out_valid), '0);
        check("rst_index", N'(out_index), '0);
        check("rst_data", out_data, '0);
        check("rst_busy", N'(busy), '0);
        check("rst_done", N'(done), '0);
        reset = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", N'(busy), '0);
        check("idle_valid", N'(out_valid), '0);

        // 2: full dump, ready held high
        run_dump(-1, -1, -1, 32, 97);

        // 3: backpressure on index 7
        run_dump(7, -1, -1, 32, 102);

        // 4: start pulse while index 3 is presented
        run_dump(-1, 3, -1, 32, 97);

        // 5: reset while index 10 is presented, then a fresh dump from index 0
        run_dump(-1, -1, 10, 10, 0);
        run_dump(-1, -1, -1, 32, 97);

        // 6: value extremes
        mem[0]  = 64'h0;
        mem[31] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_dump(-1, -1, -1, 32, 97);
        check("extreme_reg0", first_data, 64'h0);
        check("extreme_reg31", last_data, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
